// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline types for the RV32I hazard controller: forwarding selects,
// hazard FSM states and the bundled stall/flush control word.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } hazard_state_e;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic flush_d;
    logic flush_e;
    logic flush_m;
  } hazard_ctrl_t;

  // A producer matches a consumer only if it writes a non-x0 register.
  function automatic logic src_match(input logic [4:0] rd, input logic we,
                                     input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_forward_select.sv
// Per-operand EX forwarding mux select; MEM result has priority over WB.
module forward_select
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_addr_i,
  input  logic [4:0] rd_m_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_w_i,
  output fwd_sel_e   fwd_sel_o
);

  always_comb begin
    fwd_sel_o = FWD_RF;
    if (src_match(rd_m_i, reg_write_m_i, rs_addr_i)) begin
      fwd_sel_o = FWD_MEM;
    end else if (src_match(rd_w_i, reg_write_w_i, rs_addr_i)) begin
      fwd_sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stalls, branch
// flushes, multi-cycle MDU sequencing with timeout, and perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           rs1_addr_d_i,
  input  logic [4:0]           rs2_addr_d_i,
  input  logic [4:0]           rs1_addr_e_i,
  input  logic [4:0]           rs2_addr_e_i,
  input  logic [4:0]           rd_addr_e_i,
  input  logic                 is_load_e_i,
  input  logic [4:0]           rd_addr_m_i,
  input  logic                 reg_write_m_i,
  input  logic [4:0]           rd_addr_w_i,
  input  logic                 reg_write_w_i,
  input  logic                 pc_src_e_i,
  input  logic                 mdu_start_e_i,
  input  logic                 mdu_done_i,
  output logic [1:0]           forward_a_e_o,
  output logic [1:0]           forward_b_e_o,
  output logic                 stall_f_o,
  output logic                 stall_d_o,
  output logic                 stall_e_o,
  output logic                 flush_d_o,
  output logic                 flush_e_o,
  output logic                 flush_m_o,
  output logic                 mdu_busy_o,
  output logic                 mdu_timeout_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
  output logic [CNT_WIDTH-1:0] flush_count_o
);

  localparam int unsigned TW = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MDU_TIMEOUT - 1);

  hazard_state_e        state_q, state_d;
  logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic                 tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;
  hazard_ctrl_t         ctl, ctl_out;
  fwd_sel_e             fwd_a, fwd_b;
  logic                 lw_stall;

  forward_select u_fwd_a (
    .rs_addr_i     (rs1_addr_e_i),
    .rd_m_i        (rd_addr_m_i),
    .reg_write_m_i (reg_write_m_i),
    .rd_w_i        (rd_addr_w_i),
    .reg_write_w_i (reg_write_w_i),
    .fwd_sel_o     (fwd_a)
  );

  forward_select u_fwd_b (
    .rs_addr_i     (rs2_addr_e_i),
    .rd_m_i        (rd_addr_m_i),
    .reg_write_m_i (reg_write_m_i),
    .rd_w_i        (rd_addr_w_i),
    .reg_write_w_i (reg_write_w_i),
    .fwd_sel_o     (fwd_b)
  );

  assign lw_stall = src_match(rd_addr_e_i, is_load_e_i, rs1_addr_d_i) ||
                    src_match(rd_addr_e_i, is_load_e_i, rs2_addr_d_i);

  always_comb begin
    ctl       = '0;
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    tmo_d     = tmo_q;
    unique case (state_q)
      RUN: begin
        if (pc_src_e_i) begin
          ctl.flush_d = 1'b1;
          ctl.flush_e = 1'b1;
        end else if (mdu_start_e_i && !mdu_done_i) begin
          ctl.stall_f = 1'b1;
          ctl.stall_d = 1'b1;
          ctl.stall_e = 1'b1;
          ctl.flush_m = 1'b1;
          state_d     = MDU_WAIT;
          tmo_cnt_d   = '0;
        end else begin
          ctl.stall_f = lw_stall;
          ctl.stall_d = lw_stall;
          ctl.flush_e = lw_stall;
        end
      end
      MDU_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        if (mdu_done_i) begin
          state_d = RUN;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = RUN;
          tmo_d   = 1'b1;
        end else begin
          ctl.stall_f = 1'b1;
          ctl.stall_d = 1'b1;
          ctl.stall_e = 1'b1;
          ctl.flush_m = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Combinational outputs are forced quiet while reset is held.
  assign ctl_out       = rst_n ? ctl : '0;
  assign forward_a_e_o = rst_n ? fwd_a : FWD_RF;
  assign forward_b_e_o = rst_n ? fwd_b : FWD_RF;
  assign stall_f_o     = ctl_out.stall_f;
  assign stall_d_o     = ctl_out.stall_d;
  assign stall_e_o     = ctl_out.stall_e;
  assign flush_d_o     = ctl_out.flush_d;
  assign flush_e_o     = ctl_out.flush_e;
  assign flush_m_o     = ctl_out.flush_m;
  assign mdu_busy_o    = (state_q == MDU_WAIT);
  assign mdu_timeout_o = tmo_q;
  assign stall_cycles_o = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      tmo_cnt_q   <= '0;
      tmo_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
      if (ctl.stall_f && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
      if (ctl.flush_d && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl with a short MDU timeout and
// narrow counters so saturation is reachable.
module tb_hazard_ctrl;

  localparam int unsigned TMO = 8;
  localparam int unsigned CW  = 4;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic [7:0] f;  // {sf, sd, se, fd, fe, fm, busy, tmo}
  } exp_t;

  localparam logic [7:0] Z    = 8'b0000_0000;
  localparam logic [7:0] LU   = 8'b1100_1000;
  localparam logic [7:0] BR   = 8'b0001_1000;
  localparam logic [7:0] MS   = 8'b1110_0100;
  localparam logic [7:0] MW   = 8'b1110_0110;
  localparam logic [7:0] MREL = 8'b0000_0010;
  localparam logic [7:0] TB   = 8'b0000_0001;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic is_load, rw_m, rw_w, pc_src, mdu_start, mdu_done;
  logic [1:0] fa, fb;
  logic sf, sd, se, fd, fe, fm, busy, tmo;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_checks = 0, n_fail = 0;
  int exp_stall = 0, exp_flush = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr_d_i(rs1_d), .rs2_addr_d_i(rs2_d),
    .rs1_addr_e_i(rs1_e), .rs2_addr_e_i(rs2_e),
    .rd_addr_e_i(rd_e), .is_load_e_i(is_load),
    .rd_addr_m_i(rd_m), .reg_write_m_i(rw_m),
    .rd_addr_w_i(rd_w), .reg_write_w_i(rw_w),
    .pc_src_e_i(pc_src), .mdu_start_e_i(mdu_start), .mdu_done_i(mdu_done),
    .forward_a_e_o(fa), .forward_b_e_o(fb),
    .stall_f_o(sf), .stall_d_o(sd), .stall_e_o(se),
    .flush_d_o(fd), .flush_e_o(fe), .flush_m_o(fm),
    .mdu_busy_o(busy), .mdu_timeout_o(tmo),
    .stall_cycles_o(stall_cnt), .flush_count_o(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input logic inc);
    int m = (1 << CW) - 1;
    return (inc && v < m) ? v + 1 : v;
  endfunction

  task automatic clear_inputs();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {is_load, rw_m, rw_w, pc_src, mdu_start, mdu_done} = '0;
  endtask

  // Push expectation, compare at the negedge, then advance the counter model.
  task automatic step(input string tag, input logic [1:0] efa, input logic [1:0] efb,
                      input logic [7:0] ef);
    exp_t e, got;
    sb.push_back('{fa: efa, fb: efb, f: ef});
    @(negedge clk);
    e   = sb.pop_front();
    got = '{fa: fa, fb: fb, f: {sf, sd, se, fd, fe, fm, busy, tmo}};
    chk({tag, ".ctl"}, 32'(got), 32'(e));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), exp_stall);
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), exp_flush);
    @(posedge clk);
    if (rst_n) begin
      exp_stall = sat(exp_stall, e.f[7]);
      exp_flush = sat(exp_flush, e.f[4]);
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    rs1_e = 5'd5; rd_m = 5'd5; rw_m = 1'b1;
    is_load = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
    step("reset_hold", 2'b00, 2'b00, Z);
    clear_inputs();
    rst_n = 1'b1;
    step("post_reset", 2'b00, 2'b00, Z);

    rs1_e = 5'd5; rd_m = 5'd5; rw_m = 1'b1; rd_w = 5'd5; rw_w = 1'b1;
    step("fwd_mem_prio", 2'b10, 2'b00, Z);
    rw_m = 1'b0;
    step("fwd_wb", 2'b01, 2'b00, Z);
    rs1_e = 5'd0; rd_m = 5'd0; rw_m = 1'b1; rd_w = 5'd0;
    step("fwd_x0", 2'b00, 2'b00, Z);
    rs1_e = 5'd3; rd_w = 5'd3; rs2_e = 5'd9; rd_m = 5'd9;
    step("fwd_a_wb_b_mem", 2'b01, 2'b10, Z);
    clear_inputs();

    is_load = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
    step("load_use", 2'b00, 2'b00, LU);
    clear_inputs();
    step("load_use_done", 2'b00, 2'b00, Z);
    is_load = 1'b1; rd_e = 5'd0; rs1_d = 5'd0;
    step("load_rd_x0", 2'b00, 2'b00, Z);
    clear_inputs();

    pc_src = 1'b1;
    step("branch", 2'b00, 2'b00, BR);
    is_load = 1'b1; rd_e = 5'd7; rs1_d = 5'd7;
    step("branch_vs_load", 2'b00, 2'b00, BR);
    clear_inputs();
    step("branch_done", 2'b00, 2'b00, Z);

    mdu_start = 1'b1;
    step("mdu_c1", 2'b00, 2'b00, MS);
    step("mdu_c2", 2'b00, 2'b00, MW);
    step("mdu_c3", 2'b00, 2'b00, MW);
    mdu_done = 1'b1;
    step("mdu_c4_done", 2'b00, 2'b00, MREL);
    step("mdu_single", 2'b00, 2'b00, Z);
    clear_inputs();
    step("mdu_after", 2'b00, 2'b00, Z);

    mdu_start = 1'b1;
    step("tmo_entry", 2'b00, 2'b00, MS);
    for (int i = 0; i < TMO - 1; i++) step("tmo_wait", 2'b00, 2'b00, MW);
    step("tmo_release", 2'b00, 2'b00, MREL);
    clear_inputs();
    step("tmo_set", 2'b00, 2'b00, TB);
    step("tmo_sticky", 2'b00, 2'b00, TB);

    mdu_start = 1'b1;
    step("rst_mdu_entry", 2'b00, 2'b00, MS | TB);
    step("rst_mdu_busy", 2'b00, 2'b00, MW | TB);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", 32'({fa, fb, sf, sd, se, fd, fe, fm, busy, tmo}), 32'd0);
    chk("async_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("async_rst_flush_cnt", 32'(flush_cnt), 32'd0);
    exp_stall = 0; exp_flush = 0;
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b1;
    step("rst_release_run", 2'b00, 2'b00, Z);

    is_load = 1'b1; rd_e = 5'd12; rs1_d = 5'd12;
    for (int i = 0; i < 20; i++) step("stall_sat", 2'b00, 2'b00, LU);
    clear_inputs();
    step("stall_sat_hold", 2'b00, 2'b00, Z);
    chk("sat_value", 32'(stall_cnt), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RV32I core. It sits beside decode/execute and does four jobs:
- Generates EX-operand forwarding selects.
- Inserts load-use stalls and issues branch/jump flushes.
- Sequences multi-cycle MDU ops (mul/div) in EX with a busy FSM and timeout.
- Keeps saturating stall/flush performance counters.

Parameters:
MDU_TIMEOUT, 64, maximum cycles in MDU_WAIT before forced release.
CNT_WIDTH, 32, width of performance counters.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
rs1_addr_d_i  in  5  rs1 of instruction in ID
rs2_addr_d_i  in  5  rs2 of instruction in ID
rs1_addr_e_i  in  5  rs1 of instruction in EX
rs2_addr_e_i  in  5  rs2 of instruction in EX
rd_addr_e_i  in  5  rd in EX
is_load_e_i  in  1  EX instruction is a load (result_src == memory)
rd_addr_m_i  in  5  rd in MEM
reg_write_m_i  in  1  MEM writes RF
rd_addr_w_i  in  5  rd in WB
reg_write_w_i  in  1  WB writes RF
pc_src_e_i  in  1  taken branch/jump resolved in EX
mdu_start_e_i  in  1  multi-cycle MDU op present in EX
mdu_done_i  in  1  MDU result valid this cycle
forward_a_e_o  out  2  operand A select: 00 RF, 01 WB result, 10 MEM ALU result
forward_b_e_o  out  2  operand B select, same encoding
stall_f_o  out  1  hold PC
stall_d_o  out  1  hold IF/ID
stall_e_o  out  1  hold ID/EX
flush_d_o  out  1  clear IF/ID
flush_e_o  out  1  clear ID/EX (bubble)
flush_m_o  out  1  clear EX/MEM (bubble)
mdu_busy_o  out  1  FSM in MDU_WAIT
mdu_timeout_o  out  1  sticky timeout error
stall_cycles_o  out  CNT_WIDTH  cycles with stall_f_o high, saturating
flush_count_o  out  CNT_WIDTH  cycles with flush_d_o high, saturating

Behaviour:
- Reset (async, rst_n low): state RUN, timeout counter 0, mdu_timeout_o 0, both perf counters 0. All stall/flush outputs 0 and forward selects 00 while reset is held. Reset mid-MDU_WAIT aborts to RUN immediately.
- Forwarding (combinational, per operand X in {a,b}, source rsX_addr_e_i):
  - 10 if reg_write_m_i and rd_addr_m_i != 0 and rd_addr_m_i == rsX.
  - else 01 if reg_write_w_i and rd_addr_w_i != 0 and rd_addr_w_i == rsX.
  - else 00.
  - x0 is never forwarded. MEM has priority over WB.
- lw_stall = is_load_e_i && rd_addr_e_i != 0 && (rd_addr_e_i == rs1_addr_d_i || rd_addr_e_i == rs2_addr_d_i).
- FSM states: RUN, MDU_WAIT.
- RUN outputs:
  - stall_f = stall_d = lw_stall.
  - flush_e = lw_stall | pc_src_e_i.
  - flush_d = pc_src_e_i.
  - If mdu_start_e_i && !pc_src_e_i && !mdu_done_i: stall_f, stall_d, stall_e and flush_m all 1. Next state is MDU_WAIT and the timeout counter is cleared.
  - If mdu_start_e_i && mdu_done_i in the same cycle (single-cycle MDU result): no stall, stay in RUN.
- MDU_WAIT outputs:
  - stall_f, stall_d, stall_e and flush_m are 1; flush_d, flush_e are 0.
  - The counter increments each cycle.
  - On mdu_done_i: stalls drop combinationally in that same cycle, so the EX result advances into MEM. Next state RUN.
  - If the counter reaches MDU_TIMEOUT-1 without done: same release as done, set mdu_timeout_o (sticky until reset). Next state RUN.
- Simultaneous events:
  - pc_src_e_i with mdu_start_e_i or is_load_e_i is illegal, since the same EX slot holds both. If it occurs, the branch wins: flush_d = flush_e = 1, no stall, FSM stays in RUN.
  - lw_stall is ignored while in MDU_WAIT, because the whole front end is already held.
- Perf counters update at the clock edge and saturate at all-ones, no wrap.

Decomposition:
- Add to the shared pipeline types header:
  - fwd_sel_e enum (FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10).
  - hazard_state_e enum (RUN, MDU_WAIT).
  - hazard_ctrl_t struct bundling the stall/flush outputs, for stage wiring.
- One sub-module: forward_select. It is combinational and is instantiated twice, once per operand. Inputs are rs_addr, rd_m, reg_write_m, rd_w, reg_write_w; output is fwd_sel_e.

Test Plan:
- Forwarding priority and x0: rs1_e=5, rd_m=5/rw_m=1, rd_w=5/rw_w=1 -> forward_a=10. Drop rw_m -> 01. Set rs1_e=0 and rd_m=0 -> 00.
- Load-use: is_load_e=1, rd_e=7, rs2_d=7 -> one cycle of stall_f=stall_d=flush_e=1. With rd_e=0 -> no stall.
- Branch flush: pc_src_e=1 -> flush_d=flush_e=1, stalls 0, flush_count increments by 1. pc_src_e together with is_load_e hazard -> flush wins, stall_f=0.
- MDU sequence: mdu_start_e=1, mdu_done at 4th cycle -> stall_f/d/e and flush_m high for 3 cycles, low on the done cycle. mdu_busy high for cycles 2-4. stall_cycles +=3.
- Timeout: MDU_TIMEOUT=8, never assert done -> release after 8 stall cycles, mdu_timeout_o=1 and sticky. Reset clears it.
- Async reset asserted mid-MDU_WAIT -> all outputs 0 immediately, counters 0, FSM in RUN after release.
